serial_ripple_borrow_subtractor: RTL and testbench

- Bit-serial subtractor that computes a - b - borrow_in, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the 4-bit ripple-carry adder datapath.
- It trades latency for area: WIDTH cycles per operation, using a start/busy/done handshake.
- It sits beside the adder in the arithmetic steps, and its results are checked against adder-based identities.

---
 rtl/serial_ripple_borrow_subtractor_if.sv | 24 ++
 rtl/serial_ripple_borrow_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_ripple_borrow_subtractor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_ripple_borrow_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request; the slave returns status and results.
interface serial_ripple_borrow_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, out, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, out, borrow_out
    );
endinterface

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial a - b - borrow_in using one full-subtractor cell and a borrow flop.
// Takes WIDTH SHIFT cycles per operation and flags completion with a one-cycle done pulse.
module serial_ripple_borrow_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    serial_ripple_borrow_subtractor_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, a_sr_d;
    logic [WIDTH-1:0] b_sr, b_sr_d;
    logic [WIDTH-1:0] res_sr, res_sr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             br, br_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_i, b_i, diff_bit, br_next;
    logic [WIDTH-1:0] res_shift;

    // Full subtractor formed from two half subtractors on the current LSBs
    always_comb begin
        a_i       = a_sr[0];
        b_i       = b_sr[0];
        diff_bit  = a_i ^ b_i ^ br;
        br_next   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_shift = {diff_bit, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        a_sr_d       = a_sr;
        b_sr_d       = b_sr;
        res_sr_d     = res_sr;
        cnt_d        = cnt;
        br_d         = br;
        out_d        = out_q;
        borrow_out_d = borrow_out_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    br_d     = bus.borrow_in;
                    cnt_d    = '0;
                    res_sr_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr >> 1;
                b_sr_d   = b_sr >> 1;
                br_d     = br_next;
                res_sr_d = res_shift;
                cnt_d    = cnt + CW'(1);
                // Last bit: publish result and park the counter instead of wrapping
                if (cnt == CW'(WIDTH - 1)) begin
                    out_d        = res_shift;
                    borrow_out_d = br_next;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            cnt          <= '0;
            br           <= 1'b0;
            out_q        <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            a_sr         <= a_sr_d;
            b_sr         <= b_sr_d;
            res_sr       <= res_sr_d;
            cnt          <= cnt_d;
            br           <= br_d;
            out_q        <= out_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out        = out_q;
    assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Directed and exhaustive checks of the 4-bit serial borrow subtractor.
module tb_serial_ripple_borrow_subtractor;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    serial_ripple_borrow_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_ripple_borrow_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one start pulse and waits (bounded) for done; no checking here.
    task automatic run_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bi,
                          output logic [3:0] o, output logic bo, output bit timeout);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a_v; bus.b = b_v; bus.borrow_in = bi;
        @(negedge clk);
        bus.start = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        o  = bus.out;
        bo = bus.borrow_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.out !== 4'b0000) begin failures++; $display("FAIL reset_out got=%b want=0000", bus.out); end
        checks++; if (bus.borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b want=0", bus.borrow_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_timing();
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b0111; bus.b = 4'b0011; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b want busy=1 done=0", c, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
        end
        checks++; if (bus.out !== 4'b0100) begin failures++; $display("FAIL basic_out got=%b want=0100", bus.out); end
        checks++; if (bus.borrow_out !== 1'b0) begin failures++; $display("FAIL basic_borrow got=%b want=0", bus.borrow_out); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
        checks++; if (bus.out !== 4'b0100) begin failures++; $display("FAIL basic_out_hold got=%b want=0100", bus.out); end
    endtask

    task automatic test_vectors();
        logic [3:0] o; logic bo; bit to;
        run_op(4'b0011, 4'b0111, 1'b0, o, bo, to);
        checks++; if (to || o !== 4'b1100 || bo !== 1'b1) begin
            failures++; $display("FAIL vec_3_minus_7 got out=%b borrow=%b timeout=%0d want out=1100 borrow=1", o, bo, to); end
        run_op(4'b0000, 4'b0000, 1'b1, o, bo, to);
        checks++; if (to || o !== 4'b1111 || bo !== 1'b1) begin
            failures++; $display("FAIL vec_0_minus_bin got out=%b borrow=%b timeout=%0d want out=1111 borrow=1", o, bo, to); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] o; logic bo; bit to;
        run_op(4'b1111, 4'b1111, 1'b0, o, bo, to);
        checks++; if (to || o !== 4'b0000 || bo !== 1'b0) begin
            failures++; $display("FAIL b2b_first got out=%b borrow=%b timeout=%0d want out=0000 borrow=0", o, bo, to); end
        // Still in the DONE cycle: request the next operation now
        bus.start = 1'b1; bus.a = 4'b1000; bus.b = 4'b0001; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done); end
        checks++; if (bus.out !== 4'b0000) begin failures++; $display("FAIL b2b_out_hold got=%b want=0000", bus.out); end
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin to = 1'b0; break; end
            @(negedge clk);
        end
        checks++; if (to || bus.out !== 4'b0111 || bus.borrow_out !== 1'b0) begin
            failures++; $display("FAIL b2b_second got out=%b borrow=%b timeout=%0d want out=0111 borrow=0", bus.out, bus.borrow_out, to); end
    endtask

    task automatic test_ignore_start();
        bit to;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b1010; bus.b = 4'b0101; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b0000; bus.b = 4'b1111; bus.borrow_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b want=1", bus.busy); end
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin to = 1'b0; break; end
            @(negedge clk);
        end
        checks++; if (to || bus.out !== 4'b0101 || bus.borrow_out !== 1'b0) begin
            failures++; $display("FAIL ignore_result got out=%b borrow=%b timeout=%0d want out=0101 borrow=0", bus.out, bus.borrow_out, to); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b1010; bus.b = 4'b0101; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        checks++; if (bus.out !== 4'b0000 || bus.borrow_out !== 1'b0) begin
            failures++; $display("FAIL midrst_data got out=%b borrow=%b want 0000 0", bus.out, bus.borrow_out); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_no_done got activity=1 want 0"); end
    endtask

    task automatic test_exhaustive();
        logic [3:0] o; logic bo; bit to;
        logic [3:0] av, bv, exp_o; logic bi, exp_b;
        logic [4:0] sum;
        for (int k = 0; k < 512; k++) begin
            av = 4'(k >> 5); bv = 4'(k >> 1); bi = 1'(k);
            exp_o = 4'(int'(av) - int'(bv) - int'(bi));
            exp_b = (int'(av) < int'(bv) + int'(bi));
            run_op(av, bv, bi, o, bo, to);
            checks++; if (to || o !== exp_o) begin
                failures++; $display("FAIL exh_out a=%b b=%b bin=%b got=%b want=%b timeout=%0d", av, bv, bi, o, exp_o, to); end
            checks++; if (bo !== exp_b) begin
                failures++; $display("FAIL exh_borrow a=%b b=%b bin=%b got=%b want=%b", av, bv, bi, bo, exp_b); end
            sum = 5'(o) + 5'(bv) + 5'(bi);
            checks++; if (sum[3:0] !== av || sum[4] !== bo) begin
                failures++; $display("FAIL exh_adder a=%b b=%b bin=%b sum=%b want a=%b carry=%b", av, bv, bi, sum, av, bo); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_vectors();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
